sipo_frame_reg: RTL
===================

Name: sipo_frame_reg

Overview:
Parametrised serial-in/parallel-out shift register with a bit counter, selectable shift order and a valid/ready output handshake. It sits in the UART receive path after the bit-sampling logic. It assembles WIDTH serial bits into a word and presents each completed word in a holding register. Overrun is flagged when a new word completes before the previous one has been consumed.

Parameters:
WIDTH, 8, word length in bits; legal range 2..32.
LSB_FIRST, 1, 1 means the first received bit lands in bit 0 (UART order); 0 means the first received bit lands in bit WIDTH-1.
CNT_W (localparam), $clog2(WIDTH), width of bit_cnt.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
en  input  1  shift strobe; one bit is captured per clk edge while high
clr  input  1  synchronous flush of the partial word and flags
serial_in  input  1  serial data bit, sampled when en=1
out_ready  input  1  consumer accepts parallel_out while word_valid=1
shift_data  output  WIDTH  live contents of the shift register (debug/observe)
bit_cnt  output  CNT_W  number of bits captured in the current partial word
parallel_out  output  WIDTH  last completed word (holding register)
word_valid  output  1  parallel_out holds an unconsumed word
overrun  output  1  sticky flag: a word completed while the previous one was still unconsumed

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-word): shift_data=0, bit_cnt=0, parallel_out=0, word_valid=0, overrun=0. The partial word is discarded. The first en after release starts a fresh word.
- Priority at each posedge: clr > en. out_ready handling is evaluated in the same cycle as en.
- clr=1: shift_data, bit_cnt, parallel_out, word_valid and overrun all go to 0. en and out_ready are ignored that cycle.
- en=0: shift_data and bit_cnt hold.
- en=1, LSB_FIRST=1: shift_data <= {serial_in, shift_data[WIDTH-1:1]}.
- en=1, LSB_FIRST=0: shift_data <= {shift_data[WIDTH-2:0], serial_in}.
- en=1 with bit_cnt<WIDTH-1: bit_cnt increments.
- en=1 with bit_cnt==WIDTH-1 (word completion):
  - bit_cnt wraps to 0.
  - parallel_out <= the fully shifted word, including the current serial_in.
  - word_valid <= 1.
  - Latency: the word is visible in the cycle after the WIDTH-th en edge.
  - shift_data also shows the completed word until the next en.
- Handshake:
  - word_valid=1 and out_ready=1 at a posedge consumes the word; word_valid <= 0 unless a completion occurs on the same edge.
  - Consume and completion on the same edge: word_valid stays 1, parallel_out takes the new word, overrun unchanged.
  - Completion with word_valid=1 and out_ready=0: parallel_out is overwritten with the new word, word_valid stays 1, overrun <= 1.
  - overrun is sticky; only clr or rst_n clears it.
  - out_ready while word_valid=0 has no effect.
- parallel_out holds its value when a word is consumed. It changes only on completion, clr or reset.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- WIDTH=8, LSB_FIRST=1; after reset check all outputs are 0. Drive en=1 with serial_in bits 1,0,1,0,0,1,0,1 on consecutive cycles -> the cycle after the 8th edge shows parallel_out=0xA5, word_valid=1, bit_cnt=0. Pulse out_ready=1 for one cycle -> word_valid=0, parallel_out stays 0xA5.
- LSB_FIRST=0, same bit sequence -> parallel_out=0xA5 reversed = 0xA5 (palindrome check). Then send 1,1,0,0,0,0,0,0 -> parallel_out=0xC0.
- Random en gaps (en=0 between bits) sending 0x3C LSB-first -> bit_cnt advances only on en=1 cycles; parallel_out=0x3C after the 8th en.
- Send 0x11 without asserting out_ready, then send 0x22 -> parallel_out=0x22, word_valid=1, overrun=1. overrun stays 1 after consume; clr -> all outputs 0.
- Hold out_ready=1 continuously; send 0x55 then 0xAA back-to-back -> word_valid high one cycle per word, overrun stays 0. On the edge where consume coincides with completion, word_valid stays 1 and overrun stays 0.
- Reset mid-word: assert rst_n=0 asynchronously (off-edge) after 5 bits -> outputs go to 0 immediately. Release, send 0xF0 -> parallel_out=0xF0, showing no leftover bits. Repeat with WIDTH=12 sending 0xABC -> parallel_out=0xABC.

Source files
------------

// File: rtl/sipo_frame_reg.sv
// ---------------------------------------------------------------------------
// sipo_frame_reg
//
// Serial-in / parallel-out word assembler for the UART receive path. Bits
// arrive one per clk edge while en is high, are shifted into a WIDTH-bit
// register, and every WIDTH-th bit completes a word. A completed word is
// copied into a holding register and offered to the consumer with a
// valid/ready handshake. If a new word completes while the previous one is
// still unconsumed, the holding register is overwritten and a sticky
// overrun flag is raised.
//
// Parameters
//   WIDTH      word length in bits, 2..32
//   LSB_FIRST  1: first received bit lands in bit 0 (UART order)
//              0: first received bit lands in bit WIDTH-1
//   CNT_W      width of bit_cnt, $clog2(WIDTH)
//
// Ports
//   clk           system clock, rising-edge active
//   rst_n         asynchronous active-low reset
//   en            shift strobe, one bit captured per edge while high
//   clr           synchronous flush of partial word, holding register, flags
//   serial_in     serial data bit, sampled when en=1
//   out_ready     consumer accepts parallel_out while word_valid=1
//   shift_data    live shift register contents
//   bit_cnt       bits captured in the current partial word
//   parallel_out  last completed word
//   word_valid    parallel_out holds an unconsumed word
//   overrun       sticky: a word completed before the previous was consumed
// ---------------------------------------------------------------------------
module sipo_frame_reg #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1,
    localparam int CNT_W    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             serial_in,
    input  logic             out_ready,
    output logic [WIDTH-1:0] shift_data,
    output logic [CNT_W-1:0] bit_cnt,
    output logic [WIDTH-1:0] parallel_out,
    output logic             word_valid,
    output logic             overrun
);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("sipo_frame_reg: WIDTH must be in 2..32");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    // Shift one bit into the word in the configured order.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                  input logic             b);
        logic [WIDTH-1:0] r;
        if (LSB_FIRST) begin
            r = {b, cur[WIDTH-1:1]};
        end else begin
            r = {cur[WIDTH-2:0], b};
        end
        return r;
    endfunction

    logic [WIDTH-1:0] shift_p0;
    logic [CNT_W-1:0] cnt_p0;
    logic [WIDTH-1:0] hold_p1;
    logic             vld_p1;
    logic             ovr_p1;

    logic [WIDTH-1:0] shift_nxt;
    logic             complete;

    assign shift_nxt = shift_in(shift_p0, serial_in);
    // The WIDTH-th strobe of a word; the bit on serial_in is part of it.
    assign complete  = en && (cnt_p0 == LAST_BIT);

    // ---- stage p0: bit capture and counting ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_p0 <= '0;
            cnt_p0   <= '0;
        end else if (clr) begin
            shift_p0 <= '0;
            cnt_p0   <= '0;
        end else if (en) begin
            shift_p0 <= shift_nxt;
            cnt_p0   <= complete ? '0 : cnt_p0 + CNT_W'(1);
        end
    end

    // ---- stage p1: holding register and handshake ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_p1 <= '0;
            vld_p1  <= 1'b0;
            ovr_p1  <= 1'b0;
        end else if (clr) begin
            hold_p1 <= '0;
            vld_p1  <= 1'b0;
            ovr_p1  <= 1'b0;
        end else if (complete) begin
            // A completion always leaves a valid word. Only an unconsumed
            // previous word being overwritten counts as an overrun.
            hold_p1 <= shift_nxt;
            vld_p1  <= 1'b1;
            if (vld_p1 && !out_ready) begin
                ovr_p1 <= 1'b1;
            end
        end else if (vld_p1 && out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign shift_data   = shift_p0;
    assign bit_cnt      = cnt_p0;
    assign parallel_out = hold_p1;
    assign word_valid   = vld_p1;
    assign overrun      = ovr_p1;

endmodule
